// File: rtl/crypto_pkg.sv
// Shared types and constants for the crypto result-channel arbiter.
// Build option CRYPTO_ARB_CNT_EN adds per-source delivered-beat counters.
package crypto_pkg;

  localparam int DATA_W = 128;

  localparam logic SRC_AES = 1'b0;
  localparam logic SRC_RSA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOCK_AES,
    ARB_LOCK_RSA
  } arb_state_t;

endpackage

// File: rtl/crypto_out_reg.sv
// Single registered ready/valid output stage carrying data, last flag
// and source tag; drains and reloads in the same cycle for full rate.
module crypto_out_reg #(
  parameter int W = crypto_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         src_i,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o,
  output logic         out_src_o,
  output logic         out_valid_o,
  output logic         space_o
);

  logic [W-1:0] data_q;
  logic         last_q;
  logic         src_q;
  logic         valid_q;

  assign space_o = !valid_q | out_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      last_q  <= last_i;
      src_q   <= src_i;
      valid_q <= 1'b1;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign out_src_o   = src_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/crypto_out_arb.sv
// Packet-granular round-robin arbiter of AES/RSA beats onto one channel.
// Define CRYPTO_ARB_CNT_EN to add aes_beats_o/rsa_beats_o counters.
module crypto_out_arb #(
  parameter int DATA_W = crypto_pkg::DATA_W
`ifdef CRYPTO_ARB_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              aes_valid_i,
  input  logic              aes_last_i,
  input  logic [DATA_W-1:0] aes_data_i,
  output logic              aes_ready_o,
  input  logic              rsa_valid_i,
  input  logic              rsa_last_i,
  input  logic [DATA_W-1:0] rsa_data_i,
  output logic              rsa_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              out_src_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
`ifdef CRYPTO_ARB_CNT_EN
  , output logic [CNT_W-1:0] aes_beats_o
  , output logic [CNT_W-1:0] rsa_beats_o
`endif
);

  import crypto_pkg::*;

  arb_state_t state_q;
  logic       rr_q;

  logic              space;
  logic              acc_en;
  logic              aes_gnt;
  logic              rsa_gnt;
  logic              aes_acc;
  logic              rsa_acc;
  logic              acc;
  logic              sel_src;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    aes_gnt = 1'b0;
    rsa_gnt = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        aes_gnt = aes_valid_i & !(rsa_valid_i & rr_q);
        rsa_gnt = rsa_valid_i & !(aes_valid_i & !rr_q);
      end
      ARB_LOCK_AES: aes_gnt = 1'b1;
      ARB_LOCK_RSA: rsa_gnt = 1'b1;
      default: ;
    endcase
  end

  // rst gates readies so nothing is offered while held in reset
  assign acc_en      = space & !stall & rst;
  assign aes_ready_o = acc_en & aes_gnt;
  assign rsa_ready_o = acc_en & rsa_gnt;

  assign aes_acc  = aes_valid_i & aes_ready_o;
  assign rsa_acc  = rsa_valid_i & rsa_ready_o;
  assign acc      = aes_acc | rsa_acc;
  assign sel_src  = rsa_acc ? SRC_RSA : SRC_AES;
  assign sel_last = rsa_acc ? rsa_last_i : aes_last_i;
  assign sel_data = rsa_acc ? rsa_data_i : aes_data_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      rr_q    <= SRC_AES;
    end else if (acc) begin
      if (sel_last) begin
        state_q <= ARB_IDLE;
        rr_q    <= ~sel_src;
      end else if (sel_src == SRC_RSA) begin
        state_q <= ARB_LOCK_RSA;
      end else begin
        state_q <= ARB_LOCK_AES;
      end
    end
  end

  crypto_out_reg #(
    .W (DATA_W)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (acc),
    .data_i      (sel_data),
    .last_i      (sel_last),
    .src_i       (sel_src),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_src_o   (out_src_o),
    .out_valid_o (out_valid_o),
    .space_o     (space)
  );

`ifdef CRYPTO_ARB_CNT_EN
  logic [CNT_W-1:0] aes_cnt_q;
  logic [CNT_W-1:0] rsa_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aes_cnt_q <= '0;
      rsa_cnt_q <= '0;
    end else if (out_valid_o & out_ready_i) begin
      if (out_src_o == SRC_RSA) begin
        rsa_cnt_q <= rsa_cnt_q + 1'b1;
      end else begin
        aes_cnt_q <= aes_cnt_q + 1'b1;
      end
    end
  end

  assign aes_beats_o = aes_cnt_q;
  assign rsa_beats_o = rsa_cnt_q;
`endif

endmodule

// File: tb/tb_crypto_out_arb.sv
// Randomized bench for crypto_out_arb against a packet-level model
// with per-source delivery scoreboards and directed corner cases.
module tb_crypto_out_arb;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         aes_valid_i;
  logic         aes_last_i;
  logic [127:0] aes_data_i;
  logic         aes_ready_o;
  logic         rsa_valid_i;
  logic         rsa_last_i;
  logic [127:0] rsa_data_i;
  logic         rsa_ready_o;
  logic [127:0] out_data_o;
  logic         out_last_o;
  logic         out_src_o;
  logic         out_valid_o;
  logic         out_ready_i;
`ifdef CRYPTO_ARB_CNT_EN
  logic [15:0]  aes_beats_o;
  logic [15:0]  rsa_beats_o;
`endif

  crypto_out_arb dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .aes_valid_i (aes_valid_i),
    .aes_last_i  (aes_last_i),
    .aes_data_i  (aes_data_i),
    .aes_ready_o (aes_ready_o),
    .rsa_valid_i (rsa_valid_i),
    .rsa_last_i  (rsa_last_i),
    .rsa_data_i  (rsa_data_i),
    .rsa_ready_o (rsa_ready_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_src_o   (out_src_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
`ifdef CRYPTO_ARB_CNT_EN
    , .aes_beats_o (aes_beats_o)
    , .rsa_beats_o (rsa_beats_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // source drivers
  logic         sv[2];
  logic         sl[2];
  logic [127:0] sd[2];
  int           left[2];
  int           seqn[2];
  int           pq[2][$];
  logic [127:0] dq[2][$];
  logic [127:0] gq[2][$];
  int           start_pct;
  int           beat_pct;

  // packet-level reference: lock owner, preferred source, output beat
  int           lock;
  int           pref;
  logic         mv;
  logic         ml;
  logic         ms;
  logic [127:0] md;
  logic [15:0]  cnt[2];
  int           dsrc[$];

  task automatic model_reset();
    lock = -1;
    pref = 0;
    mv = 1'b0;
    ml = 1'b0;
    ms = 1'b0;
    md = '0;
    cnt[0] = '0;
    cnt[1] = '0;
    for (int s = 0; s < 2; s++) begin
      sv[s] = 1'b0;
      sl[s] = 1'b0;
      sd[s] = '0;
      left[s] = 0;
      pq[s].delete();
      dq[s].delete();
      gq[s].delete();
    end
  endtask

  task automatic step();
    logic sp;
    logic en;
    logic er[2];
    logic dr[2];
    int   win;
    int   acc;
    logic [127:0] exp_d;
    aes_valid_i = sv[0];
    aes_last_i  = sl[0];
    aes_data_i  = sd[0];
    rsa_valid_i = sv[1];
    rsa_last_i  = sl[1];
    rsa_data_i  = sd[1];
    #1;
    sp = !mv | out_ready_i;
    en = sp & !stall;
    if (lock >= 0) win = lock;
    else if (sv[0] && sv[1]) win = pref;
    else if (sv[0]) win = 0;
    else if (sv[1]) win = 1;
    else win = -1;
    for (int s = 0; s < 2; s++)
      er[s] = en && (win == s) && (lock >= 0 || sv[s]);
    dr[0] = aes_ready_o;
    dr[1] = rsa_ready_o;
    chk("aes_ready", 128'(dr[0]), 128'(er[0]));
    chk("rsa_ready", 128'(dr[1]), 128'(er[1]));
    chk("out_valid", 128'(out_valid_o), 128'(mv));
    if (mv) begin
      chk("out_data", out_data_o, md);
      chk("out_last", 128'(out_last_o), 128'(ml));
      chk("out_src", 128'(out_src_o), 128'(ms));
    end
`ifdef CRYPTO_ARB_CNT_EN
    chk("aes_beats", 128'(aes_beats_o), 128'(cnt[0]));
    chk("rsa_beats", 128'(rsa_beats_o), 128'(cnt[1]));
`endif
    if (out_valid_o && out_ready_i) begin
      int s;
      s = out_src_o ? 1 : 0;
      dsrc.push_back(s);
      if (gq[s].size() == 0) begin
        chk("spurious_beat", 128'(1), 128'(0));
      end else begin
        exp_d = gq[s].pop_front();
        chk("delivered", out_data_o, exp_d);
      end
    end
    if (mv && out_ready_i) cnt[ms] = cnt[ms] + 16'd1;
    acc = -1;
    if (er[0] && sv[0]) acc = 0;
    else if (er[1] && sv[1]) acc = 1;
    if (acc >= 0) begin
      mv = 1'b1;
      md = sd[acc];
      ml = sl[acc];
      ms = (acc == 1);
      if (sl[acc]) begin
        lock = -1;
        pref = 1 - acc;
      end else begin
        lock = acc;
      end
    end else if (out_ready_i) begin
      mv = 1'b0;
    end
    for (int s = 0; s < 2; s++) begin
      if (sv[s] && dr[s]) begin
        sv[s] = 1'b0;
        left[s]--;
      end
      if (!sv[s]) begin
        if (left[s] == 0 && pq[s].size() > 0 &&
            $urandom_range(99) < start_pct)
          left[s] = pq[s].pop_front();
        if (left[s] > 0 && $urandom_range(99) < beat_pct) begin
          sv[s] = 1'b1;
          sl[s] = (left[s] == 1);
          if (dq[s].size() > 0) sd[s] = dq[s].pop_front();
          else sd[s] = {1'(s), 15'(seqn[s]), $urandom, $urandom,
                        $urandom, 16'($urandom)};
          seqn[s]++;
          gq[s].push_back(sd[s]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_outs();
    chk("rst_valid", 128'(out_valid_o), 128'(0));
    chk("rst_data", out_data_o, 128'(0));
    chk("rst_last", 128'(out_last_o), 128'(0));
    chk("rst_src", 128'(out_src_o), 128'(0));
    chk("rst_aes_rdy", 128'(aes_ready_o), 128'(0));
    chk("rst_rsa_rdy", 128'(rsa_ready_o), 128'(0));
`ifdef CRYPTO_ARB_CNT_EN
    chk("rst_aes_cnt", 128'(aes_beats_o), 128'(0));
    chk("rst_rsa_cnt", 128'(rsa_beats_o), 128'(0));
`endif
  endtask

  initial begin
    int exp_src[4];
    n_chk = 0;
    n_pass = 0;
    seqn[0] = 0;
    seqn[1] = 0;
    model_reset();
    rst = 1'b0;
    stall = 1'b0;
    out_ready_i = 1'b1;
    aes_valid_i = 1'b1;
    aes_last_i = 1'b0;
    aes_data_i = '1;
    rsa_valid_i = 1'b1;
    rsa_last_i = 1'b0;
    rsa_data_i = '1;
    start_pct = 100;
    beat_pct = 100;
    repeat (2) @(negedge clk);
    chk_reset_outs();
    rst = 1'b1;
    run(2);

    // tie after reset: AES packet whole, then RSA packet whole
    dsrc.delete();
    pq[0].push_back(2);
    pq[1].push_back(2);
    run(8);
    exp_src = '{0, 0, 1, 1};
    chk("tie_count", 128'(dsrc.size()), 128'(4));
    for (int i = 0; i < 4 && i < dsrc.size(); i++)
      chk("tie_order", 128'(dsrc[i]), 128'(exp_src[i]));

    // AES-only 3-beat packet with fixed payload
    dq[0].push_back({16{8'h11}});
    dq[0].push_back({16{8'h22}});
    dq[0].push_back({16{8'h33}});
    pq[0].push_back(3);
    run(7);

    // second tie, then RSA mid-packet with AES waiting
    pq[0].push_back(2);
    pq[1].push_back(2);
    run(8);
    pq[1].push_back(4);
    run(2);
    pq[0].push_back(1);
    run(8);

    // output held for 5 cycles mid-packet
    pq[0].push_back(4);
    run(2);
    out_ready_i = 1'b0;
    run(5);
    out_ready_i = 1'b1;
    run(6);

    // stall during an AES packet
    pq[0].push_back(4);
    run(2);
    stall = 1'b1;
    run(4);
    stall = 1'b0;
    run(6);

    // random traffic
    start_pct = 60;
    beat_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      for (int s = 0; s < 2; s++)
        if (pq[s].size() == 0) pq[s].push_back($urandom_range(1, 4));
      out_ready_i = ($urandom_range(99) < 75);
      stall = ($urandom_range(99) < 10);
      step();
    end

    // reset in the middle of activity
    #3;
    rst = 1'b0;
    #1;
    chk_reset_outs();
    model_reset();
    stall = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    run(3);
    start_pct = 100;
    beat_pct = 100;
    pq[1].push_back(2);
    pq[0].push_back(3);
    run(10);
    start_pct = 60;
    beat_pct = 70;
    for (int i = 0; i < 1000; i++) begin
      for (int s = 0; s < 2; s++)
        if (pq[s].size() == 0) pq[s].push_back($urandom_range(1, 4));
      out_ready_i = ($urandom_range(99) < 70);
      stall = ($urandom_range(99) < 10);
      step();
    end

    // drain: finish open packets, start no new ones
    for (int s = 0; s < 2; s++) pq[s].delete();
    beat_pct = 100;
    stall = 1'b0;
    out_ready_i = 1'b1;
    run(40);
    chk("drain_aes", 128'(gq[0].size()), 128'(0));
    chk("drain_rsa", 128'(gq[1].size()), 128'(0));
    chk("drain_valid", 128'(out_valid_o), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
